id_ex_stage: RTL

- ID/EX pipeline register of the 5-stage pipeline. Captures decoded operands from the register-file read ports and produces forwarded EX operands.
- Bypasses the same-cycle WB write into the captured operands, detects load-use hazards (stalls ID, injects a bubble) and applies branch flushes.
- Keeps saturating stall and flush event counters.

---
 rtl/id_ex_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures decoded operands with WB bypass, inserts bubbles on
// load-use hazards and flushes, forwards MEM/WB results into the EX operands.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_pc4,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rR1,
    input  logic [4:0]       id_rR2,
    input  logic [XLEN-1:0]  id_rD1,
    input  logic [XLEN-1:0]  id_rD2,
    input  logic [4:0]       id_wR,
    input  logic [1:0]       id_wD_sel,
    input  logic             id_we,
    input  logic             id_mem_we,
    input  logic [3:0]       id_alu_op,
    input  logic             flush,
    input  logic             mem_we,
    input  logic [4:0]       mem_wR,
    input  logic [1:0]       mem_wD_sel,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_pc4,
    input  logic             wb_we,
    input  logic [4:0]       wb_wR,
    input  logic [XLEN-1:0]  wb_wD,
    output logic             ex_valid,
    output logic             ex_we,
    output logic             ex_mem_we,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_pc4,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rR1,
    output logic [4:0]       ex_rR2,
    output logic [4:0]       ex_wR,
    output logic [1:0]       ex_wD_sel,
    output logic [3:0]       ex_alu_op,
    output logic [XLEN-1:0]  ex_op1,
    output logic [XLEN-1:0]  ex_op2,
    output logic             id_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] SEL_ALU    = 2'b00;
    localparam logic [1:0] SEL_DRAM   = 2'b01;
    localparam logic [1:0] SEL_BUBBLE = 2'b10;
    localparam logic [1:0] SEL_PC4    = 2'b11;

    logic [XLEN-1:0] rd1_q;
    logic [XLEN-1:0] rd2_q;
    logic            load_use;
    logic            bubble;
    logic [XLEN-1:0] cap_rd1;
    logic [XLEN-1:0] cap_rd2;
    logic [XLEN-1:0] mem_data;
    logic            mem_hit1;
    logic            mem_hit2;
    logic            wb_hit1;
    logic            wb_hit2;

    always_comb begin
        load_use = ex_valid & ex_we & (ex_wD_sel == SEL_DRAM) & (ex_wR != 5'd0)
                 & ((ex_wR == id_rR1) | (ex_wR == id_rR2)) & id_valid;
        id_stall = load_use & ~flush;
        bubble   = flush | load_use;
    end

    // The register file writes on the same edge we capture, so read data may be stale.
    always_comb begin
        cap_rd1 = id_rD1;
        cap_rd2 = id_rD2;
        if (wb_we && wb_wR != 5'd0 && wb_wR == id_rR1) cap_rd1 = wb_wD;
        if (wb_we && wb_wR != 5'd0 && wb_wR == id_rR2) cap_rd2 = wb_wD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_we     <= 1'b0;
            ex_mem_we <= 1'b0;
            ex_pc     <= '0;
            ex_pc4    <= '0;
            ex_imm    <= '0;
            ex_rR1    <= '0;
            ex_rR2    <= '0;
            ex_wR     <= '0;
            ex_wD_sel <= SEL_ALU;
            ex_alu_op <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
        end else if (bubble) begin
            ex_valid  <= 1'b0;
            ex_we     <= 1'b0;
            ex_mem_we <= 1'b0;
            ex_pc     <= '0;
            ex_pc4    <= '0;
            ex_imm    <= '0;
            ex_rR1    <= '0;
            ex_rR2    <= '0;
            ex_wR     <= '0;
            ex_wD_sel <= SEL_BUBBLE;
            ex_alu_op <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
        end else begin
            ex_valid  <= id_valid;
            ex_we     <= id_we;
            ex_mem_we <= id_mem_we;
            ex_pc     <= id_pc;
            ex_pc4    <= id_pc4;
            ex_imm    <= id_imm;
            ex_rR1    <= id_rR1;
            ex_rR2    <= id_rR2;
            ex_wR     <= id_wR;
            ex_wD_sel <= id_wD_sel;
            ex_alu_op <= id_alu_op;
            rd1_q     <= cap_rd1;
            rd2_q     <= cap_rd2;
        end
    end

    // A load in MEM has no data yet; the load-use bubble keeps consumers out of its way.
    always_comb begin
        mem_data = (mem_wD_sel == SEL_PC4) ? mem_pc4 : mem_alu_result;
        mem_hit1 = mem_we & (mem_wR != 5'd0) & (mem_wR == ex_rR1) & (mem_wD_sel != SEL_DRAM);
        mem_hit2 = mem_we & (mem_wR != 5'd0) & (mem_wR == ex_rR2) & (mem_wD_sel != SEL_DRAM);
        wb_hit1  = wb_we & (wb_wR != 5'd0) & (wb_wR == ex_rR1);
        wb_hit2  = wb_we & (wb_wR != 5'd0) & (wb_wR == ex_rR2);
        ex_op1   = rd1_q;
        ex_op2   = rd2_q;
        if (mem_hit1)     ex_op1 = mem_data;
        else if (wb_hit1) ex_op1 = wb_wD;
        if (mem_hit2)     ex_op2 = mem_data;
        else if (wb_hit2) ex_op2 = wb_wD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (id_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (id_valid || ex_valid) && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
